// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory stage: Funct3 access sizes, FSM states
// and the packed result of store-lane formatting.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

    typedef struct packed {
        logic        aligned;
        logic [3:0]  byte_en;
        logic [31:0] word;
    } st_fmt_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Lane formatting for the data RAM: load extraction/extension from a raw word,
// and store byte-enable/replication plus alignment checking for a request.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] rd_word,
    output logic [31:0] load_value,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_lane,
    input  logic [31:0] wr_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic        aligned
);

    function automatic logic [31:0] load_extract(
        input logic [2:0]  f3,
        input logic [1:0]  lane,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    result = {{24{b[7]}}, b};
            F3_BU:   result = {24'd0, b};
            F3_H:    result = {{16{h[15]}}, h};
            F3_HU:   result = {16'd0, h};
            F3_W:    result = word;
            default: result = 32'd0;
        endcase
        return result;
    endfunction

    // Stores replicate the operand into every lane so the RAM only needs
    // byte enables to pick the target bytes.
    function automatic st_fmt_t store_format(
        input logic [2:0]  f3,
        input logic [1:0]  lane,
        input logic [31:0] wd
    );
        st_fmt_t r;
        r = '0;
        case (f3)
            F3_B, F3_BU: begin
                r.aligned = 1'b1;
                r.byte_en = 4'b0001 << lane;
                r.word    = {4{wd[7:0]}};
            end
            F3_H, F3_HU: begin
                r.aligned = ~lane[0];
                r.byte_en = lane[1] ? 4'b1100 : 4'b0011;
                r.word    = {2{wd[15:0]}};
            end
            F3_W: begin
                r.aligned = (lane == 2'b00);
                r.byte_en = 4'b1111;
                r.word    = wd;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    st_fmt_t st_fmt;

    always_comb begin
        load_value = load_extract(ld_funct3, ld_lane, rd_word);
        st_fmt     = store_format(st_funct3, st_lane, wr_data);
        byte_en    = st_fmt.byte_en;
        store_word = st_fmt.word;
        aligned    = st_fmt.aligned;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory stage controller: captures an EX/MEM request, stalls
// the pipeline for WAIT_CYC extra cycles, then performs the RAM access.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int WAIT_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            Funct3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  mem_stall,
    output logic                  misalign
);

    localparam int IDX_W = DM_ADDRESS - 2;
    localparam int DEPTH = 2 ** IDX_W;

    dmem_state_t state_reg, state_next;
    logic [2:0]  counter_reg, counter_next;

    // Captured request; the store word and byte enables are kept pre-formatted.
    logic [IDX_W-1:0]  idx_reg;
    logic [1:0]        lane_reg;
    logic [2:0]        f3_reg;
    logic              is_read_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wword_reg;

    // Format of the last completed load; rd_data is rebuilt from the RAM output.
    logic              ld_valid_reg;
    logic [2:0]        ld_f3_reg;
    logic [1:0]        ld_lane_reg;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       mem_q;

    logic              req;
    logic              in_aligned;
    logic [3:0]        in_be;
    logic [31:0]       in_word;
    logic [31:0]       load_value;

    logic              capture;
    logic              access;
    logic              mis_pulse;
    logic              stall;

    logic              acc_live;
    logic              acc_read;
    logic [IDX_W-1:0]  acc_idx;
    logic [1:0]        acc_lane;
    logic [2:0]        acc_f3;
    logic [3:0]        acc_be;
    logic [31:0]       acc_word;
    logic              mem_we;
    logic              mem_re;

    dmem_lane_fmt u_lane_fmt (
        .ld_funct3  (ld_f3_reg),
        .ld_lane    (ld_lane_reg),
        .rd_word    (mem_q),
        .load_value (load_value),
        .st_funct3  (Funct3),
        .st_lane    (addr[1:0]),
        .wr_data    (wr_data),
        .byte_en    (in_be),
        .store_word (in_word),
        .aligned    (in_aligned)
    );

    assign req = MemRead | MemWrite;

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        capture      = 1'b0;
        access       = 1'b0;
        mis_pulse    = 1'b0;
        stall        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (in_aligned) begin
                        capture      = 1'b1;
                        stall        = 1'b1;
                        counter_next = 3'(WAIT_CYC);
                        if (WAIT_CYC == 0) begin
                            access     = 1'b1;
                            state_next = DONE;
                        end else begin
                            state_next = BUSY;
                        end
                    end else begin
                        mis_pulse = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall        = 1'b1;
                counter_next = counter_reg - 3'd1;
                if (counter_reg <= 3'd1) begin
                    access     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // EX/MEM still shows the finished instruction; do not re-issue.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            access    = 1'b0;
            capture   = 1'b0;
            mis_pulse = 1'b0;
            stall     = 1'b0;
        end
    end

    // A zero-wait access happens on the request edge, so it uses the live inputs.
    always_comb begin
        acc_live = (state_reg == IDLE);
        acc_read = acc_live ? MemRead             : is_read_reg;
        acc_idx  = acc_live ? addr[DM_ADDRESS-1:2] : idx_reg;
        acc_lane = acc_live ? addr[1:0]           : lane_reg;
        acc_f3   = acc_live ? Funct3              : f3_reg;
        acc_be   = acc_live ? in_be               : be_reg;
        acc_word = acc_live ? in_word             : wword_reg;
        mem_we   = access & ~acc_read;
        mem_re   = access & acc_read;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            counter_reg  <= 3'd0;
            idx_reg      <= '0;
            lane_reg     <= 2'd0;
            f3_reg       <= F3_W;
            is_read_reg  <= 1'b0;
            be_reg       <= 4'd0;
            wword_reg    <= 32'd0;
            ld_valid_reg <= 1'b0;
            ld_f3_reg    <= F3_W;
            ld_lane_reg  <= 2'd0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            if (capture) begin
                idx_reg     <= addr[DM_ADDRESS-1:2];
                lane_reg    <= addr[1:0];
                f3_reg      <= Funct3;
                is_read_reg <= MemRead;
                be_reg      <= in_be;
                wword_reg   <= in_word;
            end
            if (mem_re) begin
                ld_valid_reg <= 1'b1;
                ld_f3_reg    <= acc_f3;
                ld_lane_reg  <= acc_lane;
            end else if (mis_pulse) begin
                ld_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][b*8 +: 8] <= acc_word[b*8 +: 8];
                end
            end
        end
        if (mem_re) begin
            mem_q <= mem[acc_idx];
        end
    end

    assign rd_data   = ld_valid_reg ? DATA_W'(load_value) : '0;
    assign mem_stall = stall;
    assign misalign  = mis_pulse;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with WAIT_CYC=2, one with WAIT_CYC=0.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_rd, a_wr;
    logic [8:0]  a_addr;
    logic [31:0] a_wdata;
    logic [2:0]  a_f3;
    logic [31:0] a_rdata;
    logic        a_stall, a_mis;

    logic        b_rd, b_wr;
    logic [8:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_f3;
    logic [31:0] b_rdata;
    logic        b_stall, b_mis;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYC(2)) dut (
        .clk(clk), .reset(reset), .MemRead(a_rd), .MemWrite(a_wr), .addr(a_addr),
        .wr_data(a_wdata), .Funct3(a_f3), .rd_data(a_rdata), .mem_stall(a_stall),
        .misalign(a_mis)
    );

    dmem_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr), .addr(b_addr),
        .wr_data(b_wdata), .Funct3(b_f3), .rd_data(b_rdata), .mem_stall(b_stall),
        .misalign(b_mis)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit fast, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] d);
        if (fast) begin
            b_rd = rd; b_wr = wr; b_f3 = f3; b_addr = a; b_wdata = d;
        end else begin
            a_rd = rd; a_wr = wr; a_f3 = f3; a_addr = a; a_wdata = d;
        end
    endtask

    // Legal access: stall must hold for WAIT_CYC+1 cycles, then DONE shows the result.
    task automatic run(input bit fast, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [8:0] a, input logic [31:0] d, input string tag,
                       input logic [31:0] exp);
        int nst;
        nst = fast ? 1 : 3;
        @(posedge clk); #1;
        drive(fast, rd, wr, f3, a, d);
        for (int i = 0; i < nst; i++) begin
            @(negedge clk);
            chk({tag, " stall"}, {31'd0, fast ? b_stall : a_stall}, 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        chk({tag, " done_stall"}, {31'd0, fast ? b_stall : a_stall}, 32'd0);
        chk({tag, " done_mis"}, {31'd0, fast ? b_mis : a_mis}, 32'd0);
        chk({tag, " rd_data"}, fast ? b_rdata : a_rdata, exp);
        $display("txn %s addr=%h f3=%0d rd_data=%h", tag, a, f3, fast ? b_rdata : a_rdata);
    endtask

    task automatic mis(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [8:0] a, input string tag);
        @(posedge clk); #1;
        drive(1'b0, rd, wr, f3, a, 32'h0);
        @(negedge clk);
        chk({tag, " mis"}, {31'd0, a_mis}, 32'd1);
        chk({tag, " stall"}, {31'd0, a_stall}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, F3_W, 9'h0, 32'h0);
        @(negedge clk);
        chk({tag, " mis_after"}, {31'd0, a_mis}, 32'd0);
        chk({tag, " rd_zero"}, a_rdata, 32'd0);
        chk({tag, " stall_after"}, {31'd0, a_stall}, 32'd0);
        $display("txn %s addr=%h f3=%0d misaligned", tag, a, f3);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, F3_W, 9'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, F3_W, 9'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset rd_data", a_rdata, 32'd0);
        chk("reset stall", {31'd0, a_stall}, 32'd0);
        chk("reset mis", {31'd0, a_mis}, 32'd0);
        chk("reset rd_data0", b_rdata, 32'd0);
        $display("txn reset");

        run(0, 0, 1, F3_W,  9'h010, 32'hDEADBEEF, "sw 010", 32'h0);
        run(0, 1, 0, F3_W,  9'h010, 32'h0,        "lw 010", 32'hDEADBEEF);
        run(0, 0, 1, F3_W,  9'h010, 32'h80FF7F01, "sw 010b", 32'hDEADBEEF);
        run(0, 1, 0, F3_B,  9'h013, 32'h0,        "lb 013", 32'hFFFFFF80);
        run(0, 1, 0, F3_BU, 9'h013, 32'h0,        "lbu 013", 32'h00000080);
        run(0, 1, 0, F3_H,  9'h010, 32'h0,        "lh 010", 32'h00007F01);
        run(0, 1, 0, F3_HU, 9'h012, 32'h0,        "lhu 012", 32'h000080FF);
        run(0, 0, 1, F3_W,  9'h010, 32'h11223344, "sw 010c", 32'h000080FF);
        run(0, 0, 1, F3_B,  9'h011, 32'h123456AA, "sb 011", 32'h000080FF);
        run(0, 1, 0, F3_W,  9'h010, 32'h0,        "lw after sb", 32'h1122AA44);
        run(0, 0, 1, F3_H,  9'h012, 32'h5555BEEF, "sh 012", 32'h1122AA44);
        run(0, 1, 0, F3_W,  9'h010, 32'h0,        "lw after sh", 32'hBEEFAA44);

        mis(1, 0, F3_W, 9'h012, "lw 012");
        run(0, 1, 0, F3_W,  9'h010, 32'h0,        "lw after mis", 32'hBEEFAA44);
        mis(0, 1, F3_H, 9'h011, "sh 011");
        mis(1, 0, 3'd3, 9'h010, "f3=3");
        run(0, 1, 0, F3_W,  9'h010, 32'h0,        "lw unchanged", 32'hBEEFAA44);

        run(0, 1, 1, F3_W,  9'h010, 32'h0,        "rd+wr", 32'hBEEFAA44);
        run(0, 1, 0, F3_W,  9'h010, 32'h0,        "lw no write", 32'hBEEFAA44);

        run(0, 0, 1, F3_W,  9'h1FC, 32'hCAFEF00D, "sw top", 32'hBEEFAA44);
        run(0, 1, 0, F3_W,  9'h1FC, 32'h0,        "lw top", 32'hCAFEF00D);
        run(0, 1, 0, F3_W,  9'h010, 32'h0,        "lw no alias", 32'hBEEFAA44);

        run(0, 0, 1, F3_W,  9'h020, 32'hAAAA5555, "sw 020", 32'hBEEFAA44);
        run(0, 1, 0, F3_W,  9'h020, 32'h0,        "lw 020", 32'hAAAA5555);

        // Reset lands on the edge where the pending store would have written.
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, F3_W, 9'h020, 32'h12345678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, F3_W, 9'h0, 32'h0);
        @(negedge clk);
        chk("rst busy stall", {31'd0, a_stall}, 32'd0);
        chk("rst busy rd_data", a_rdata, 32'd0);
        chk("rst busy mis", {31'd0, a_mis}, 32'd0);
        $display("txn reset during busy store");
        run(0, 1, 0, F3_W,  9'h020, 32'h0,        "lw 020 old", 32'hAAAA5555);

        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, F3_W, 9'h0, 32'h0);

        run(1, 0, 1, F3_W,  9'h040, 32'h01020304, "z sw 040", 32'h0);
        run(1, 1, 0, F3_W,  9'h040, 32'h0,        "z lw 040", 32'h01020304);
        run(1, 0, 1, F3_B,  9'h041, 32'h00000077, "z sb 041", 32'h01020304);
        run(1, 1, 0, F3_W,  9'h040, 32'h0,        "z lw 040b", 32'h01027704);
        run(1, 1, 0, F3_HU, 9'h042, 32'h0,        "z lhu 042", 32'h00000102);
        run(1, 0, 1, F3_H,  9'h040, 32'h0000FFEE, "z sh 040", 32'h00000102);
        run(1, 1, 0, F3_H,  9'h040, 32'h0,        "z lh 040", 32'hFFFFFFEE);

        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, F3_W, 9'h0, 32'h0);
        @(negedge clk);
        chk("z idle stall", {31'd0, b_stall}, 32'd0);
        chk("z idle rd_data hold", b_rdata, 32'hFFFFFFEE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory stage controller sitting directly downstream of the EX/MEM pipeline register. It consumes MemRead, MemWrite, ALU address, store data and funct3, and produces load data for the MEM/WB register.
- Models a multi-cycle, word-organised, little-endian data RAM. Handles byte/halfword/word loads and stores with lane alignment and sign/zero extension.
- Raises mem_stall so the pipeline freezes IF..EX/MEM while an access is in flight, and flags misaligned accesses.

Parameters:
- DM_ADDRESS, 9, byte-address width; array depth = 2**(DM_ADDRESS-2) 32-bit words.
- DATA_W, 32, data width; only 32 is supported.
- WAIT_CYC, 2, extra access wait cycles, legal range 0..7.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from EX/MEM.
- MemWrite  in  1  store request from EX/MEM.
- addr  in  DM_ADDRESS  byte address (ALU result low bits).
- wr_data  in  DATA_W  store data, forwarded operand B.
- Funct3  in  3  access size/sign: 0=b, 1=h, 2=w, 4=bu, 5=hu.
- rd_data  out  DATA_W  load result, valid in DONE and held until the next completed load.
- mem_stall  out  1  high while the access is not yet complete; pipeline holds EX/MEM and injects a bubble into MEM/WB.
- misalign  out  1  one-cycle pulse on a misaligned or unsupported access.

Behaviour:
- Reset: state=IDLE, rd_data=0, mem_stall=0, misalign=0, counter=0. Array contents are not cleared.
- Reset asserted mid-access: next state is IDLE. A pending store is discarded and the array is not written.
- States are IDLE, BUSY and DONE.
- IDLE with no request: mem_stall=0 and nothing changes.
- IDLE with a legal request:
  - Capture addr, wr_data, Funct3 and the read/write kind into internal registers.
  - counter <= WAIT_CYC.
  - mem_stall=1 combinationally in this same cycle.
  - Next state is BUSY, or DONE directly with the access performed on this edge if WAIT_CYC=0.
- BUSY: mem_stall=1 and counter decrements each cycle. In the cycle counter==1, the array access is performed at the closing edge and the next state is DONE.
- DONE:
  - mem_stall=0; rd_data holds the extended load value.
  - Inputs still show the same instruction because EX/MEM was frozen. They are ignored, with no re-issue.
  - The pipeline advances at the closing edge and the next state is IDLE.
- Timing: a request first seen in IDLE at cycle t keeps mem_stall high over cycles t..t+WAIT_CYC. rd_data is valid at cycle t+WAIT_CYC+1 and is captured by MEM/WB at the end of that cycle.
- Alignment: w requires addr[1:0]=0; h/hu require addr[0]=0; b/bu are always aligned.
- Misaligned access or Funct3 in {3,6,7}, seen in IDLE:
  - No array access; rd_data <= 0.
  - misalign=1 for exactly that cycle; mem_stall=0.
  - State stays IDLE, so the instruction retires as a no-op.
- MemRead and MemWrite both high: handled as a load only, with the write suppressed.
- Load extraction:
  - Word index = addr[DM_ADDRESS-1:2].
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - b/h sign-extend from bit 7/15; bu/hu zero-extend.
- Store: byte enables come from lane and size; data is replicated into the lanes (sb: wr_data[7:0] to all four lanes; sh: [15:0] to both halves). Only enabled bytes change.
- Stores leave rd_data unchanged.
- Addresses wrap modulo 2**DM_ADDRESS; the top word is legal.

Decomposition:
- Package dmem_pkg: localparams F3_B, F3_H, F3_W, F3_BU, F3_HU, plus typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t.
- Sub-module dmem_lane_fmt (combinational), with two functions:
  - Given Funct3, addr[1:0], raw read word and wr_data: produce the extended load value, the 4-bit byte-enable, the replicated store word and an aligned flag.
  - Is unit-testable on its own.
- dmem_ctrl holds the FSM, counter, request registers and array.

Test Plan:
- WAIT_CYC=2: sw 0xDEADBEEF at 0x010, then lw 0x010 -> mem_stall high 3 cycles per access; rd_data=0xDEADBEEF in DONE.
- Word 0x010=0x80FF7F01: lb 0x013 -> 0xFFFFFF80; lbu 0x013 -> 0x00000080; lh 0x010 -> 0x00007F01; lhu 0x012 -> 0x000080FF.
- sb 0xAA at 0x011 over 0x11223344 -> word becomes 0x1122AA44; sh 0xBEEF at 0x012 -> 0xBEEFAA44.
- lw 0x012 -> misalign pulses 1 cycle, mem_stall stays 0, rd_data=0, memory unchanged; Funct3=3 gives the same result.
- WAIT_CYC=0: lw issues one stall cycle and DONE follows next. Back-to-back lw/sw with EX/MEM changing after DONE -> each access is performed exactly once.
- Reset asserted in BUSY during sw 0x12345678 to 0x020 -> IDLE next cycle, mem_stall=0, rd_data=0; a later lw 0x020 returns the old value.
